rvlab_tlul_rr_arbiter: RTL and testbench

- Shares one TL-UL device port among NUM_HOSTS TL-UL hosts using round-robin arbitration on the A channel.
- Routes each D-channel response back to the issuing host through an in-order routing FIFO.
- Sits between student/DMA-style hosts and a single slave (e.g. a student fast device or the DDR port) so that more hosts can be added without widening xbar_main.
- The attached device must respond in request order.

---
 rtl/rvlab_arb_pkg.sv | 57 +++++
 rtl/rvlab_arb_route_fifo.sv | 65 ++++++
 rtl/rvlab_tlul_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_rvlab_tlul_rr_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rvlab_arb_pkg.sv
// rvlab_arb_pkg
//   Shared types and sizing helpers for the TL-UL round-robin arbiter.
//   - tl_h2d_t / tl_d2h_t : the lab's TL-UL request/response bundles
//   - route_entry_t       : one routing-FIFO entry (host index, sized for 8 hosts)
//   - idx_width()         : host index width for a given host count
//   - cnt_width()         : outstanding-counter width for a given depth
package rvlab_arb_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  // Route entries are sized for the largest supported host count so the
  // FIFO type does not depend on the arbiter's parameters.
  localparam int unsigned ROUTE_W = 3;
  typedef logic [ROUTE_W-1:0] route_entry_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned m);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rvlab_arb_route_fifo.sv
// rvlab_arb_route_fifo
//   In-order FIFO of host indices: one entry per accepted request, popped when
//   the matching response is handed back.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset (resets to empty)
//     push, wdata : enqueue wdata (ignored when full)
//     pop         : dequeue the head (ignored when empty)
//     head        : oldest entry
//     empty, full : status flags
//     count       : number of stored entries
module rvlab_arb_route_fifo
  import rvlab_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = cnt_width(DEPTH),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  route_entry_t     wdata,
  input  logic             pop,
  output route_entry_t     head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  route_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Explicit wrap keeps DEPTH = 1 correct, where the pointer has a spare bit.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rvlab_tlul_rr_arbiter.sv
// rvlab_tlul_rr_arbiter
//   Shares one TL-UL device port among NUM_HOSTS hosts. A-channel requests are
//   arbitrated round-robin; D-channel responses are routed back through an
//   in-order FIFO, so the device must answer in request order.
//   Ports:
//     clk_i, rst_ni     : clock, asynchronous active-low reset
//     tl_h_i / tl_h_o   : per-host request in / response + a_ready out
//     tl_d_o / tl_d_i   : request out to the device / response + a_ready in
//     busy_o            : at least one request is awaiting its response
//     unexpected_rsp_o  : one-cycle pulse after a response arrived with nothing outstanding
module rvlab_tlul_rr_arbiter
  import rvlab_arb_pkg::*;
#(
  parameter int unsigned NUM_HOSTS       = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  tl_h2d_t [NUM_HOSTS-1:0]   tl_h_i,
  output tl_d2h_t [NUM_HOSTS-1:0]   tl_h_o,
  output tl_h2d_t                   tl_d_o,
  input  tl_d2h_t                   tl_d_i,
  output logic                      busy_o,
  output logic                      unexpected_rsp_o
);

  localparam int unsigned IDX_W = idx_width(NUM_HOSTS);
  localparam int unsigned CNT_W = cnt_width(MAX_OUTSTANDING);

  logic [IDX_W-1:0] rr_ptr_q, lock_idx_q, grant, grant_next;
  logic             lock_q, unexp_q;
  logic             issue_en, a_hs, d_ready, d_hs;
  route_entry_t     head_entry;
  logic             fifo_empty, fifo_full;
  logic [CNT_W-1:0] count;

  // fifo_full is exactly count == MAX_OUTSTANDING on the registered count, so
  // a pop in this cycle only frees a slot from the next cycle on. Qualifying
  // with rst_ni keeps all handshake outputs low while reset is held.
  assign issue_en = rst_ni && !fifo_full;

  // Round-robin search from rr_ptr_q upward with wrap. Walking the offsets from
  // high to low lets the closest requesting host win. While locked, the grant is
  // pinned so the A payload presented to the device cannot change.
  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    grant    = rr_ptr_q;
    if (lock_q) begin
      grant = lock_idx_q;
    end else begin
      for (int k = NUM_HOSTS - 1; k >= 0; k--) begin
        cand = int'(rr_ptr_q) + k;
        if (cand >= NUM_HOSTS) cand = cand - NUM_HOSTS;
        cand_idx = IDX_W'(cand);
        if (tl_h_i[cand_idx].a_valid) grant = cand_idx;
      end
    end
  end

  assign grant_next = (grant == IDX_W'(NUM_HOSTS - 1)) ? '0 : grant + IDX_W'(1);

  // With nothing outstanding, any response is accepted and dropped.
  always_comb begin
    d_ready = 1'b1;
    if (!fifo_empty) begin
      for (int i = 0; i < NUM_HOSTS; i++) begin
        if (head_entry == route_entry_t'(i)) d_ready = tl_h_i[i].d_ready;
      end
    end
  end

  always_comb begin
    tl_d_o         = tl_h_i[grant];
    tl_d_o.a_valid = tl_h_i[grant].a_valid && issue_en;
    tl_d_o.d_ready = d_ready;
  end

  assign a_hs = tl_d_o.a_valid && tl_d_i.a_ready;
  assign d_hs = tl_d_i.d_valid && d_ready;

  // Every host sees the device D fields; only the FIFO head sees d_valid.
  always_comb begin
    for (int i = 0; i < NUM_HOSTS; i++) begin
      tl_h_o[i]         = tl_d_i;
      tl_h_o[i].a_ready = (grant == IDX_W'(i)) && issue_en && tl_d_i.a_ready;
      tl_h_o[i].d_valid = rst_ni && !fifo_empty &&
                          (head_entry == route_entry_t'(i)) && tl_d_i.d_valid;
    end
  end

  // The lock engages when the device stalls a valid request and releases on
  // the handshake. If the locked host drops a_valid, the lock is simply held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      unexp_q    <= 1'b0;
    end else begin
      if (a_hs) begin
        lock_q   <= 1'b0;
        rr_ptr_q <= grant_next;
      end else if (tl_d_o.a_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant;
      end
      unexp_q <= d_hs && fifo_empty;
    end
  end

  rvlab_arb_route_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_route_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (a_hs),
    .wdata (route_entry_t'(grant)),
    .pop   (d_hs && !fifo_empty),
    .head  (head_entry),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (count)
  );

  assign busy_o           = (count != '0);
  assign unexpected_rsp_o = unexp_q;

endmodule

// File: tb/tb_rvlab_tlul_rr_arbiter.sv
// tb_rvlab_tlul_rr_arbiter
//   Directed bench for rvlab_tlul_rr_arbiter with two hosts and four outstanding
//   slots. The bench plays the device by hand; host 0 uses source 0xA0, host 1
//   uses source 0xA1. Inputs change 2-3 time units after the rising edge and
//   outputs are checked before the next rising edge.
module tb_rvlab_tlul_rr_arbiter;
  import rvlab_arb_pkg::*;

  localparam int unsigned NUM_HOSTS       = 2;
  localparam int unsigned MAX_OUTSTANDING = 4;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  tl_h2d_t [NUM_HOSTS-1:0] tl_h_i;
  tl_d2h_t [NUM_HOSTS-1:0] tl_h_o;
  tl_h2d_t                 tl_d_o;
  tl_d2h_t                 tl_d_i;
  logic                    busy_o;
  logic                    unexpected_rsp_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  rvlab_tlul_rr_arbiter #(
    .NUM_HOSTS       (NUM_HOSTS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .tl_h_i           (tl_h_i),
    .tl_h_o           (tl_h_o),
    .tl_d_o           (tl_d_o),
    .tl_d_i           (tl_d_i),
    .busy_o           (busy_o),
    .unexpected_rsp_o (unexpected_rsp_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] addr0,
                               input logic v1, input logic [31:0] addr1,
                               input logic dev_a_ready, input logic dev_d_valid,
                               input logic [7:0] dev_d_source);
    tl_h_i[0].a_valid   = v0;
    tl_h_i[0].a_address = addr0;
    tl_h_i[1].a_valid   = v1;
    tl_h_i[1].a_address = addr1;
    tl_d_i.a_ready      = dev_a_ready;
    tl_d_i.d_valid      = dev_d_valid;
    tl_d_i.d_source     = dev_d_source;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int heads [3];

    // Idle bus, reset asserted; host 0 already requesting and device ready.
    rst_ni = 1'b0;
    tl_h_i = '0;
    for (int i = 0; i < NUM_HOSTS; i++) begin
      tl_h_i[i].a_opcode = Get;
      tl_h_i[i].a_source = 8'hA0 + 8'(i);
      tl_h_i[i].a_mask   = 4'hF;
      tl_h_i[i].a_size   = 2'd2;
      tl_h_i[i].d_ready  = 1'b1;
    end
    tl_d_i          = '0;
    tl_d_i.d_opcode = AccessAckData;
    tl_d_i.d_data   = 32'hD00D_0000;
    applyStimulus(1, 32'h10, 0, 32'h0, 1, 0, 8'h00);
    checkOutput("rst dev a_valid", 32'(tl_d_o.a_valid), 0);
    checkOutput("rst a_ready0", 32'(tl_h_o[0].a_ready), 0);
    checkOutput("rst a_ready1", 32'(tl_h_o[1].a_ready), 0);
    checkOutput("rst d_valid0", 32'(tl_h_o[0].d_valid), 0);
    checkOutput("rst busy", 32'(busy_o), 0);
    checkOutput("rst unexpected", 32'(unexpected_rsp_o), 0);
    tick();
    tick();
    rst_ni = 1'b1;

    // Single Get from host 0 to 0x10, answered one cycle later.
    applyStimulus(1, 32'h10, 0, 32'h0, 1, 0, 8'h00);
    checkOutput("t1 dev a_valid", 32'(tl_d_o.a_valid), 1);
    checkOutput("t1 dev addr", tl_d_o.a_address, 32'h10);
    checkOutput("t1 dev source", 32'(tl_d_o.a_source), 32'hA0);
    checkOutput("t1 dev opcode", 32'(tl_d_o.a_opcode), 32'h4);
    checkOutput("t1 a_ready0", 32'(tl_h_o[0].a_ready), 1);
    checkOutput("t1 a_ready1", 32'(tl_h_o[1].a_ready), 0);
    tick();
    applyStimulus(0, 32'h10, 0, 32'h0, 1, 1, 8'hA0);
    checkOutput("t1 busy", 32'(busy_o), 1);
    checkOutput("t1 d_valid0", 32'(tl_h_o[0].d_valid), 1);
    checkOutput("t1 d_source0", 32'(tl_h_o[0].d_source), 32'hA0);
    checkOutput("t1 d_data0", tl_h_o[0].d_data, 32'hD00D_0000);
    checkOutput("t1 d_valid1", 32'(tl_h_o[1].d_valid), 0);
    tick();
    applyStimulus(0, 32'h10, 0, 32'h0, 1, 0, 8'h00);
    checkOutput("t1 busy idle", 32'(busy_o), 0);
    checkOutput("t1 unexpected", 32'(unexpected_rsp_o), 0);

    // Both hosts request continuously; pointer is 1 after host 0's grant,
    // so grants go 1,0,1,0 and fill all four slots.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'h100, 1, 32'h200, 1, 0, 8'h00);
      checkOutput("t2 grant source", 32'(tl_d_o.a_source), (k % 2 == 0) ? 32'hA1 : 32'hA0);
      checkOutput("t2 grant a_ready", 32'((k % 2 == 0) ? tl_h_o[1].a_ready : tl_h_o[0].a_ready), 1);
      tick();
    end
    applyStimulus(1, 32'h100, 1, 32'h200, 1, 0, 8'h00);
    checkOutput("t3 full dev a_valid", 32'(tl_d_o.a_valid), 0);
    checkOutput("t3 full a_ready0", 32'(tl_h_o[0].a_ready), 0);
    checkOutput("t3 full a_ready1", 32'(tl_h_o[1].a_ready), 0);
    checkOutput("t3 full busy", 32'(busy_o), 1);
    tick();

    // First response goes to host 1; its slot is usable only next cycle.
    applyStimulus(1, 32'h100, 1, 32'h200, 1, 1, 8'hA1);
    checkOutput("t3 rsp1 d_valid1", 32'(tl_h_o[1].d_valid), 1);
    checkOutput("t3 rsp1 d_valid0", 32'(tl_h_o[0].d_valid), 0);
    checkOutput("t3 pop same cycle a_ready1", 32'(tl_h_o[1].a_ready), 0);
    tick();
    applyStimulus(1, 32'h100, 1, 32'h200, 1, 1, 8'hA0);
    checkOutput("t3 rsp2 d_valid0", 32'(tl_h_o[0].d_valid), 1);
    checkOutput("t3 rsp2 d_valid1", 32'(tl_h_o[1].d_valid), 0);
    checkOutput("t3 fifth a_ready1", 32'(tl_h_o[1].a_ready), 1);
    checkOutput("t3 fifth source", 32'(tl_d_o.a_source), 32'hA1);
    tick();

    // Drain the remaining responses in push order: 1, 0, 1.
    heads = '{1, 0, 1};
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 32'h100, 0, 32'h200, 1, 1, (heads[k] == 1) ? 8'hA1 : 8'hA0);
      checkOutput("drain d_valid0", 32'(tl_h_o[0].d_valid), (heads[k] == 0) ? 32'd1 : 32'd0);
      checkOutput("drain d_valid1", 32'(tl_h_o[1].d_valid), (heads[k] == 1) ? 32'd1 : 32'd0);
      tick();
    end
    applyStimulus(0, 32'h100, 0, 32'h200, 1, 0, 8'h00);
    checkOutput("drain busy", 32'(busy_o), 0);

    // Device stalls host 1 for three cycles; pointer is 0 at this point.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 32'h100, 1, 32'h200, 0, 0, 8'h00);
      checkOutput("lock dev a_valid", 32'(tl_d_o.a_valid), 1);
      checkOutput("lock dev addr", tl_d_o.a_address, 32'h200);
      checkOutput("lock a_ready1", 32'(tl_h_o[1].a_ready), 0);
      tick();
    end
    applyStimulus(1, 32'h100, 1, 32'h200, 0, 0, 8'h00);
    checkOutput("lock host0 up addr", tl_d_o.a_address, 32'h200);
    checkOutput("lock host0 up a_ready0", 32'(tl_h_o[0].a_ready), 0);
    tick();
    applyStimulus(1, 32'h100, 0, 32'h200, 0, 0, 8'h00);
    checkOutput("lock dropout dev a_valid", 32'(tl_d_o.a_valid), 0);
    checkOutput("lock dropout addr", tl_d_o.a_address, 32'h200);
    checkOutput("lock dropout a_ready0", 32'(tl_h_o[0].a_ready), 0);
    tick();
    applyStimulus(1, 32'h100, 1, 32'h200, 1, 0, 8'h00);
    checkOutput("lock hs addr", tl_d_o.a_address, 32'h200);
    checkOutput("lock hs a_ready1", 32'(tl_h_o[1].a_ready), 1);
    checkOutput("lock hs a_ready0", 32'(tl_h_o[0].a_ready), 0);
    tick();
    applyStimulus(1, 32'h100, 0, 32'h200, 1, 0, 8'h00);
    checkOutput("after lock addr", tl_d_o.a_address, 32'h100);
    checkOutput("after lock a_ready0", 32'(tl_h_o[0].a_ready), 1);
    tick();

    // Reset with two requests outstanding; pointer would otherwise favour host 1.
    applyStimulus(0, 32'h100, 0, 32'h200, 1, 0, 8'h00);
    checkOutput("pre-reset busy", 32'(busy_o), 1);
    applyStimulus(1, 32'h100, 1, 32'h200, 1, 0, 8'h00);
    rst_ni = 1'b0;
    #1;
    checkOutput("async rst dev a_valid", 32'(tl_d_o.a_valid), 0);
    checkOutput("async rst busy", 32'(busy_o), 0);
    checkOutput("async rst a_ready0", 32'(tl_h_o[0].a_ready), 0);
    checkOutput("async rst a_ready1", 32'(tl_h_o[1].a_ready), 0);
    tick();
    rst_ni = 1'b1;
    applyStimulus(1, 32'h100, 1, 32'h200, 1, 0, 8'h00);
    checkOutput("post rst source", 32'(tl_d_o.a_source), 32'hA0);
    checkOutput("post rst a_ready0", 32'(tl_h_o[0].a_ready), 1);
    checkOutput("post rst a_ready1", 32'(tl_h_o[1].a_ready), 0);
    tick();
    applyStimulus(0, 32'h100, 0, 32'h200, 1, 1, 8'hA0);
    checkOutput("post rst rsp d_valid0", 32'(tl_h_o[0].d_valid), 1);
    tick();

    // Response with nothing outstanding: dropped, flagged one cycle later.
    applyStimulus(0, 32'h100, 0, 32'h200, 1, 1, 8'h55);
    checkOutput("unexp d_valid0", 32'(tl_h_o[0].d_valid), 0);
    checkOutput("unexp d_valid1", 32'(tl_h_o[1].d_valid), 0);
    checkOutput("unexp dev d_ready", 32'(tl_d_o.d_ready), 1);
    checkOutput("unexp not yet", 32'(unexpected_rsp_o), 0);
    tick();
    applyStimulus(0, 32'h100, 0, 32'h200, 1, 0, 8'h00);
    checkOutput("unexp pulse", 32'(unexpected_rsp_o), 1);
    checkOutput("unexp busy", 32'(busy_o), 0);
    tick();
    checkOutput("unexp pulse end", 32'(unexpected_rsp_o), 0);
    checkOutput("unexp busy end", 32'(busy_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
